// File: rtl/i2c_reg_seq_pkg.sv
// Shared constants for the I2C register-access sequencer: command codes, status codes, FSM states.
// Latency: n/a (definitions only).  Backpressure: n/a.
// I2C_SEQ_ADDR16_EN selects 16-bit register addresses (two address bytes, MSB first).
package i2c_reg_seq_pkg;

`ifdef I2C_SEQ_ADDR16_EN
    localparam int REG_W      = 16;
    localparam int ADDR_BYTES = 2;
`else
    localparam int REG_W      = 8;
    localparam int ADDR_BYTES = 1;
`endif

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_RESTART = 3'd1;
    localparam logic [2:0] CMD_STOP    = 3'd2;
    localparam logic [2:0] CMD_READ    = 3'd3;
    localparam logic [2:0] CMD_WRITE   = 3'd4;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_ADDR_NACK = 2'b01;
    localparam logic [1:0] ERR_DATA_NACK = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_t;

    // Index of the STOP step in the write / read step lists.
    function automatic logic [2:0] stop_step(input logic rnw);
        return rnw ? 3'(5 + ADDR_BYTES) : 3'(3 + ADDR_BYTES);
    endfunction

endpackage

// File: rtl/i2c_seq_step_dec.sv
// Maps (step, rnw, latched request) to the master command/data for that step.
// Latency: combinational.  Backpressure: none.
module i2c_seq_step_dec
    import i2c_reg_seq_pkg::*;
(
    input  logic [2:0]       step,
    input  logic             rnw,
    input  logic [6:0]       dev,
    input  logic [REG_W-1:0] reg_addr,
    input  logic [7:0]       wdata,
    output logic [2:0]       cmd,
    output logic [7:0]       data,
    output logic             is_addr_byte,
    output logic             is_last
);

    logic [15:0] reg16;
    logic [3:0]  k;

    always_comb begin
        reg16        = 16'(reg_addr);
        // Canonical index follows the 16-bit list; the 8-bit build skips the high address byte.
        k            = (ADDR_BYTES == 1 && step >= 3'd2) ? {1'b0, step} + 4'd1 : {1'b0, step};
        cmd          = CMD_STOP;
        data         = 8'h00;
        is_addr_byte = 1'b0;
        case (k)
            4'd0: cmd = CMD_START;
            4'd1: begin
                cmd          = CMD_WRITE;
                data         = {dev, 1'b0};
                is_addr_byte = 1'b1;
            end
            4'd2: begin
                cmd  = CMD_WRITE;
                data = reg16[15:8];
            end
            4'd3: begin
                cmd  = CMD_WRITE;
                data = reg16[7:0];
            end
            4'd4: begin
                if (rnw) begin
                    cmd = CMD_RESTART;
                end else begin
                    cmd  = CMD_WRITE;
                    data = wdata;
                end
            end
            4'd5: begin
                if (rnw) begin
                    cmd          = CMD_WRITE;
                    data         = {dev, 1'b1};
                    is_addr_byte = 1'b1;
                end
            end
            4'd6: begin
                cmd  = CMD_READ;
                data = 8'h01;
            end
            default: cmd = CMD_STOP;
        endcase
        is_last = (cmd == CMD_STOP);
    end

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer: one register read/write request -> START..STOP command list to the I2C byte master.
// Latency: one master command per ISSUE/WAIT_BUSY/WAIT_DONE round; rsp_valid one cycle after DONE.
// Backpressure: req_ready only in IDLE; commands wait for m_ready. Build option I2C_SEQ_ADDR16_EN.
module i2c_reg_seq
    import i2c_reg_seq_pkg::*;
#(
    parameter logic [15:0] CLK_DIV        = 16'd120,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rnw,
    input  logic [6:0]       req_dev,
    input  logic [REG_W-1:0] req_reg,
    input  logic [7:0]       req_wdata,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic [1:0]       rsp_err,
    output logic             m_write,
    output logic [2:0]       m_cmd,
    output logic [7:0]       m_data,
    output logic [15:0]      m_clock_divisor,
    input  logic             m_ready,
    input  logic [7:0]       m_data_out,
    input  logic             m_ack,
    input  logic             m_done_tick
);

    seq_state_t       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic             rnw_q, rnw_d;
    logic [6:0]       dev_q, dev_d;
    logic [REG_W-1:0] reg_q, reg_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             ack_q, ack_d;
    logic             m_write_q, m_write_d;
    logic [2:0]       m_cmd_q, m_cmd_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [1:0]       err_q, err_d;

    logic [2:0] dec_cmd;
    logic [7:0] dec_data;
    logic       dec_is_addr;
    logic       dec_is_last;
    logic       waiting;

    i2c_seq_step_dec u_dec (
        .step         (step_q),
        .rnw          (rnw_q),
        .dev          (dev_q),
        .reg_addr     (reg_q),
        .wdata        (wdata_q),
        .cmd          (dec_cmd),
        .data         (dec_data),
        .is_addr_byte (dec_is_addr),
        .is_last      (dec_is_last)
    );

    assign waiting = (state_q == ST_ISSUE) || (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        rnw_d       = rnw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        byte_d      = byte_q;
        ack_d       = ack_q;
        m_write_d   = 1'b0;
        m_cmd_d     = m_cmd_q;
        m_data_d    = m_data_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;

        if (m_done_tick) begin
            byte_d = m_data_out;
            ack_d  = m_ack;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rnw_d   = req_rnw;
                    dev_d   = req_dev;
                    reg_d   = req_reg;
                    wdata_d = req_wdata;
                    step_d  = 3'd0;
                    err_d   = ERR_OK;
                    rdata_d = 8'h00;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    m_write_d = 1'b1;
                    m_cmd_d   = dec_cmd;
                    m_data_d  = dec_data;
                    state_d   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!m_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // ack_d/byte_d so a done_tick coincident with m_ready is already seen.
                if (m_ready) begin
                    if (dec_is_last) begin
                        state_d = ST_DONE;
                    end else if (dec_cmd == CMD_WRITE && ack_d) begin
                        if (err_q == ERR_OK) begin
                            err_d = dec_is_addr ? ERR_ADDR_NACK : ERR_DATA_NACK;
                        end
                        step_d  = stop_step(rnw_q);
                        state_d = ST_ISSUE;
                    end else begin
                        if (dec_cmd == CMD_READ) begin
                            rdata_d = byte_d;
                        end
                        step_d  = step_q + 3'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A wait state that has lasted TIMEOUT_CYCLES cycles is abandoned without a STOP.
        if (waiting && state_d == state_q && cnt_q == TIMEOUT_CYCLES - 16'd1) begin
            state_d = ST_DONE;
            if (err_q == ERR_OK) begin
                err_d = ERR_TIMEOUT;
            end
        end

        cnt_d = (waiting && state_d == state_q) ? cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 3'd0;
            rnw_q       <= 1'b0;
            dev_q       <= 7'd0;
            reg_q       <= '0;
            wdata_q     <= 8'h00;
            cnt_q       <= 16'd0;
            byte_q      <= 8'h00;
            ack_q       <= 1'b0;
            m_write_q   <= 1'b0;
            m_cmd_q     <= CMD_START;
            m_data_q    <= 8'h00;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            err_q       <= ERR_OK;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rnw_q       <= rnw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            ack_q       <= ack_d;
            m_write_q   <= m_write_d;
            m_cmd_q     <= m_cmd_d;
            m_data_q    <= m_data_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign m_write         = m_write_q;
    assign m_cmd           = m_cmd_q;
    assign m_data          = m_data_q;
    assign m_clock_divisor = CLK_DIV;

endmodule
